// File: rtl/hazard_stall_controller_if.sv
// Pipeline-control bundle between the hazard/stall controller and the 5-stage datapath.
// The master side is the datapath; the slave side is the controller.
interface hazard_stall_controller_if;
   logic       IDEX_memread_ctrl;
   logic [4:0] IDEX_reg_rt;
   logic [4:0] IFID_reg_rs;
   logic [4:0] IFID_reg_rt;
   logic       IFID_uses_rt;
   logic       IDEX_muldiv_ctrl;
   logic       branch_taken;
   logic       muldiv_done;
   logic       pc_write;
   logic       IFID_write;
   logic       IFID_flush;
   logic       IDEX_write;
   logic       IDEX_bubble;
   logic       EXMEM_bubble;
   logic       muldiv_go;
   logic       muldiv_timeout_err;

   modport master (
      output IDEX_memread_ctrl, IDEX_reg_rt, IFID_reg_rs, IFID_reg_rt, IFID_uses_rt,
             IDEX_muldiv_ctrl, branch_taken, muldiv_done,
      input  pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_bubble,
             muldiv_go, muldiv_timeout_err
   );

   modport slave (
      input  IDEX_memread_ctrl, IDEX_reg_rt, IFID_reg_rs, IFID_reg_rt, IFID_uses_rt,
             IDEX_muldiv_ctrl, branch_taken, muldiv_done,
      output pc_write, IFID_write, IFID_flush, IDEX_write, IDEX_bubble, EXMEM_bubble,
             muldiv_go, muldiv_timeout_err
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use stall, branch flush and mul/div freeze sequencing for the 5-stage MIPS core.
// Optional macro HAZARD_PERF_CNT_EN adds a saturating 32-bit stall_cycles counter.
module hazard_stall_controller #(
   parameter int LOAD_USE_CYCLES = 1,
   parameter int MULDIV_TIMEOUT  = 64
) (
   input  logic                       clk,
   input  logic                       reset,
   hazard_stall_controller_if.slave   hz
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0]                stall_cycles
`endif
);
   typedef enum logic [1:0] {RUN, LOAD_STALL, MULDIV_WAIT} state_t;

   localparam logic [1:0] REMAIN_INIT = 2'((LOAD_USE_CYCLES > 1) ? (LOAD_USE_CYCLES - 2) : 0);
   localparam logic [7:0] TIMEOUT     = 8'(MULDIV_TIMEOUT);

   state_t     state_q, state_d;
   logic [1:0] remain_q, remain_d;
   logic [7:0] wait_cnt_q, wait_cnt_d;
   logic       err_q, err_d;
   logic [7:0] wait_next;
   logic       load_use;

   logic pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_bubble, muldiv_go;

   assign load_use = hz.IDEX_memread_ctrl && (hz.IDEX_reg_rt != 5'd0) &&
                     ((hz.IDEX_reg_rt == hz.IFID_reg_rs) ||
                      (hz.IFID_uses_rt && (hz.IDEX_reg_rt == hz.IFID_reg_rt)));

   // The count seen during a WAIT cycle is one past the stored value, so the first WAIT cycle is 1.
   assign wait_next = (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;

   always_comb begin
      state_d      = state_q;
      remain_d     = remain_q;
      wait_cnt_d   = wait_cnt_q;
      err_d        = err_q;
      pc_write     = 1'b1;
      ifid_write   = 1'b1;
      ifid_flush   = 1'b0;
      idex_write   = 1'b1;
      idex_bubble  = 1'b0;
      exmem_bubble = 1'b0;
      muldiv_go    = 1'b0;

      case (state_q)
         RUN: begin
            if (hz.IDEX_muldiv_ctrl) begin
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               idex_write   = 1'b0;
               exmem_bubble = 1'b1;
               muldiv_go    = 1'b1;
               state_d      = MULDIV_WAIT;
               wait_cnt_d   = 8'd0;
            end else if (hz.branch_taken) begin
               ifid_flush  = 1'b1;
               idex_bubble = 1'b1;
            end else if (load_use) begin
               pc_write    = 1'b0;
               ifid_write  = 1'b0;
               idex_bubble = 1'b1;
               if (LOAD_USE_CYCLES > 1) begin
                  state_d  = LOAD_STALL;
                  remain_d = REMAIN_INIT;
               end
            end
         end
         LOAD_STALL: begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            if (remain_q == 2'd0) state_d = RUN;
            else                  remain_d = remain_q - 2'd1;
         end
         MULDIV_WAIT: begin
            wait_cnt_d = wait_next;
            if (hz.muldiv_done) begin
               state_d = RUN;
            end else if (wait_next == TIMEOUT) begin
               exmem_bubble = 1'b1;
               err_d        = 1'b1;
               state_d      = RUN;
            end else begin
               pc_write     = 1'b0;
               ifid_write   = 1'b0;
               idex_write   = 1'b0;
               exmem_bubble = 1'b1;
            end
         end
         default: state_d = RUN;
      endcase

      if (reset) begin
         pc_write     = 1'b0;
         ifid_write   = 1'b0;
         idex_write   = 1'b0;
         ifid_flush   = 1'b1;
         idex_bubble  = 1'b1;
         exmem_bubble = 1'b1;
         muldiv_go    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= RUN;
         remain_q   <= 2'd0;
         wait_cnt_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         remain_q   <= remain_d;
         wait_cnt_q <= wait_cnt_d;
         err_q      <= err_d;
      end
   end

   assign hz.pc_write           = pc_write;
   assign hz.IFID_write         = ifid_write;
   assign hz.IFID_flush         = ifid_flush;
   assign hz.IDEX_write         = idex_write;
   assign hz.IDEX_bubble        = idex_bubble;
   assign hz.EXMEM_bubble       = exmem_bubble;
   assign hz.muldiv_go          = muldiv_go;
   assign hz.muldiv_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [31:0] perf_q, perf_d;

   always_comb begin
      perf_d = perf_q;
      if (!pc_write && (perf_q != 32'hFFFF_FFFF)) perf_d = perf_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) perf_q <= 32'd0;
      else       perf_q <= perf_d;
   end

   assign stall_cycles = perf_q;
`endif
endmodule
